execute_alu_stage: RTL and testbench

- Execute stage directly downstream of the instruction decoder; consumes decoded operand0, shifted operand1, 4-bit data-processing opcode and condition code.
- Evaluates the condition against the architectural NZCV register, computes the ALU result and updates NZCV.
- Registers a register-file writeback request.
- Single-cycle, stallable; holds the only NZCV state in the core.

---
 rtl/execute_alu_stage_pkg.sv | 53 +++++
 rtl/execute_alu_stage_cond_check.sv | 43 ++++
 rtl/execute_alu_stage.sv | 152 +++++++++++++++
 tb/tb_execute_alu_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_alu_stage_pkg.sv
// Shared definitions for the execute stage: data-processing opcodes, condition codes, NZCV bit positions.
// Latency: n/a (constants and pure helper function only).
// Backpressure: n/a.
package execute_alu_stage_pkg;

  // Data-processing opcodes
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Condition codes (instruction[31:28])
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Compare/test opcodes only update flags and never write the register file
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/execute_alu_stage_cond_check.sv
// Evaluates a 4-bit condition code against an NZCV flags vector; shared with branch logic.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module cond_check
  import execute_alu_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition field into a single pass/fail bit
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c & !z;
      CC_LS: pass = !c | z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z & (n == v);
      CC_LE: pass = z | (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_alu_stage.sv
// Execute stage: condition check, ALU, NZCV update and registered register-file writeback request.
// Latency: 1 cycle from accept (in_valid & !stall) to out_valid/wr_en.
// Backpressure: stall freezes every register including flags; in_ready = !stall.
module execute_alu_stage
  import execute_alu_stage_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic [3:0]        cond,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] operand0,
  input  logic [DATA_W-1:0] operand1,
  input  logic              shifter_carry,
  input  logic              update_flags,
  input  logic [3:0]        dest_addr,
  output logic              out_valid,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        flags,
  output logic              cond_pass
);

  logic              fire;
  logic              pass;
  logic              test_op;
  logic              arith_op;
  logic              flags_upd;
  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;
  logic              add_cin;
  logic [DATA_W:0]   sum;
  logic              add_v;
  logic [DATA_W-1:0] result;
  logic [3:0]        flags_q;
  logic [3:0]        flags_nxt;

  assign in_ready = !stall;
  assign fire     = in_valid & !stall;
  assign flags    = flags_q;
  assign test_op  = is_test_op(operation);

  // Condition is always judged against the architectural flags; a back-to-back
  // instruction sees the previous one's update because flags_q is already written.
  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_q),
    .pass  (pass)
  );

  // Steer operands into the single adder; subtraction is x + ~y + cin
  always_comb begin
    add_x    = operand0;
    add_y    = operand1;
    add_cin  = 1'b0;
    arith_op = 1'b1;
    case (operation)
      OP_SUB, OP_CMP: begin
        add_y   = ~operand1;
        add_cin = 1'b1;
      end
      OP_RSB: begin
        add_x   = operand1;
        add_y   = ~operand0;
        add_cin = 1'b1;
      end
      OP_ADD, OP_CMN: begin
        add_cin = 1'b0;
      end
      OP_ADC: begin
        add_cin = flags_q[FLAG_C];
      end
      OP_SBC: begin
        add_y   = ~operand1;
        add_cin = flags_q[FLAG_C];
      end
      OP_RSC: begin
        add_x   = operand1;
        add_y   = ~operand0;
        add_cin = flags_q[FLAG_C];
      end
      default: arith_op = 1'b0;
    endcase
  end

  // Carry-out lands in bit DATA_W, so for subtracts C is NOT borrow
  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
  assign add_v = (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                 (sum[DATA_W-1] != add_x[DATA_W-1]);

  // Select the logical result or the adder output
  always_comb begin
    result = sum[DATA_W-1:0];
    case (operation)
      OP_AND, OP_TST: result = operand0 & operand1;
      OP_EOR, OP_TEQ: result = operand0 ^ operand1;
      OP_ORR:         result = operand0 | operand1;
      OP_MOV:         result = operand1;
      OP_BIC:         result = operand0 & ~operand1;
      OP_MVN:         result = ~operand1;
      default:        result = sum[DATA_W-1:0];
    endcase
  end

  // Candidate NZCV; logical ops take C from the shifter and leave V alone
  always_comb begin
    flags_nxt         = flags_q;
    flags_nxt[FLAG_N] = result[DATA_W-1];
    flags_nxt[FLAG_Z] = (result == '0);
    if (arith_op) begin
      flags_nxt[FLAG_C] = sum[DATA_W];
      flags_nxt[FLAG_V] = add_v;
    end else begin
      flags_nxt[FLAG_C] = shifter_carry;
    end
  end

  assign flags_upd = pass & (update_flags | test_op);

  // Stage registers: reset beats stall, stall holds everything, idle drops the strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q   <= FLAGS_RST;
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cond_pass <= 1'b0;
    end else if (stall) begin
      flags_q   <= flags_q;
    end else if (fire) begin
      out_valid <= 1'b1;
      cond_pass <= pass;
      wr_en     <= pass & !test_op;
      wr_addr   <= dest_addr;
      wr_data   <= result;
      if (flags_upd) begin
        flags_q <= flags_nxt;
      end
    end else begin
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_alu_stage.sv
module tb_execute_alu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic [3:0]  cond;
  logic [3:0]  operation;
  logic [31:0] operand0;
  logic [31:0] operand1;
  logic        shifter_carry;
  logic        update_flags;
  logic [3:0]  dest_addr;
  logic        out_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  flags;
  logic        cond_pass;

  int total = 0;
  int bad   = 0;

  execute_alu_stage #(.DATA_W(32), .FLAGS_RST(4'b0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .stall         (stall),
    .cond          (cond),
    .operation     (operation),
    .operand0      (operand0),
    .operand1      (operand1),
    .shifter_carry (shifter_carry),
    .update_flags  (update_flags),
    .dest_addr     (dest_addr),
    .out_valid     (out_valid),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .flags         (flags),
    .cond_pass     (cond_pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic [3:0] cc, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic sc,
                       input logic s, input logic [3:0] d);
    in_valid = v; stall = st; cond = cc; operation = op;
    operand0 = a; operand1 = b; shifter_carry = sc; update_flags = s; dest_addr = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  typedef struct packed { logic [31:0] res; logic c; logic v; } arith_t;

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // x + y + cin computed exactly
  function automatic arith_t ref_add(input logic [31:0] x, input logic [31:0] y, input logic cin);
    arith_t r;
    longint unsigned u;
    longint s;
    u = longint'({32'b0, x}) + longint'({32'b0, y}) + longint'(cin);
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
    r.res = u[31:0];
    r.c   = u[32];
    r.v   = ovf(s);
    return r;
  endfunction

  // x - y - borrow; C means "no borrow"
  function automatic arith_t ref_sub(input logic [31:0] x, input logic [31:0] y, input logic borrow);
    arith_t r;
    longint unsigned ux, uy;
    longint s;
    ux = {32'b0, x};
    uy = {32'b0, y};
    s  = longint'($signed(x)) - longint'($signed(y)) - longint'(borrow);
    r.res = x - y - {31'b0, borrow};
    r.c   = (ux >= uy + longint'(borrow));
    r.v   = ovf(s);
    return r;
  endfunction

  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0: return z;        4'd1: return !z;
      4'd2: return c;        4'd3: return !c;
      4'd4: return n;        4'd5: return !n;
      4'd6: return v;        4'd7: return !v;
      4'd8: return c && !z;  4'd9: return !c || z;
      4'd10: return n == v;  4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns result and the flags that would be written
  task automatic ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic sc,
                         output logic [31:0] res, output logic [3:0] nf);
    arith_t r;
    logic is_arith;
    logic cf;
    cf = f[1];
    is_arith = 1'b1;
    res = 32'h0;
    r = '0;
    case (op)
      4'h2, 4'hA: r = ref_sub(a, b, 1'b0);
      4'h3:       r = ref_sub(b, a, 1'b0);
      4'h4, 4'hB: r = ref_add(a, b, 1'b0);
      4'h5:       r = ref_add(a, b, cf);
      4'h6:       r = ref_sub(a, b, !cf);
      4'h7:       r = ref_sub(b, a, !cf);
      default:    is_arith = 1'b0;
    endcase
    if (is_arith) res = r.res;
    else begin
      case (op)
        4'h0, 4'h8: res = a & b;
        4'h1, 4'h9: res = a ^ b;
        4'hC:       res = a | b;
        4'hD:       res = b;
        4'hE:       res = a & ~b;
        default:    res = ~b;
      endcase
    end
    nf[3] = res[31];
    nf[2] = (res == 32'h0);
    nf[1] = is_arith ? r.c : sc;
    nf[0] = is_arith ? r.v : f[0];
  endtask

  logic        m_ov, m_we, m_cp;
  logic [3:0]  m_wa, m_fl;
  logic [31:0] m_wd;

  task automatic model_step();
    logic [31:0] res;
    logic [3:0]  nf;
    logic        p, is_test;
    if (rst) begin
      m_ov = 0; m_we = 0; m_cp = 0; m_wa = 0; m_wd = 0; m_fl = 4'b0000;
    end else if (stall) begin
      // everything holds
    end else if (in_valid) begin
      ref_alu(operation, operand0, operand1, m_fl, shifter_carry, res, nf);
      p = ref_cond(cond, m_fl);
      is_test = (operation >= 4'h8) && (operation <= 4'hB);
      m_ov = 1; m_cp = p; m_we = p && !is_test; m_wa = dest_addr; m_wd = res;
      if (p && (update_flags || is_test)) m_fl = nf;
    end else begin
      m_ov = 0; m_we = 0;
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  cc;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sc;
    logic        s;
    logic [3:0]  d;
    logic        e_pass;
    logic        e_we;
    logic [31:0] e_data;
    logic [3:0]  e_flags;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] cc, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic sc, input logic s, input logic [3:0] d,
                              input logic e_pass, input logic e_we, input logic [31:0] e_data,
                              input logic [3:0] e_flags);
    vec_t v;
    v.cc = cc; v.op = op; v.a = a; v.b = b; v.sc = sc; v.s = s; v.d = d;
    v.e_pass = e_pass; v.e_we = e_we; v.e_data = e_data; v.e_flags = e_flags;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int wr_count;

    // Vectors run back to back from reset flags 0000; each row sees the previous row's flags
    tbl[0]  = mk(4'hE, 4'h4, 32'h7FFFFFFF, 32'h1,        0, 1, 4'd3,  1, 1, 32'h80000000, 4'b1001); // ADDS
    tbl[1]  = mk(4'hE, 4'hA, 32'd5,        32'd5,        0, 0, 4'd4,  1, 0, 32'h0,        4'b0110); // CMP
    tbl[2]  = mk(4'h1, 4'h2, 32'd9,        32'd2,        0, 1, 4'd5,  0, 0, 32'h7,        4'b0110); // SUBNE fails
    tbl[3]  = mk(4'hE, 4'h5, 32'hFFFFFFFF, 32'h0,        0, 1, 4'd6,  1, 1, 32'h0,        4'b0110); // ADCS C=1
    tbl[4]  = mk(4'hE, 4'h6, 32'h0,        32'h1,        0, 1, 4'd7,  1, 1, 32'hFFFFFFFF, 4'b1000); // SBCS C=1
    tbl[5]  = mk(4'hE, 4'hA, 32'h80000000, 32'h1,        0, 0, 4'd0,  1, 0, 32'h7FFFFFFF, 4'b0011); // CMP ovf
    tbl[6]  = mk(4'hE, 4'hD, 32'h12345678, 32'h0,        1, 1, 4'd8,  1, 1, 32'h0,        4'b0111); // MOVS V kept
    tbl[7]  = mk(4'hC, 4'h4, 32'd1,        32'd1,        0, 1, 4'd9,  0, 0, 32'h2,        4'b0111); // ADDGT fails
    tbl[8]  = mk(4'hD, 4'h9, 32'hF0,       32'hF0,       0, 0, 4'd1,  1, 0, 32'h0,        4'b0101); // TEQLE
    tbl[9]  = mk(4'hE, 4'h3, 32'd3,        32'd10,       0, 1, 4'd10, 1, 1, 32'h7,        4'b0010); // RSBS
    tbl[10] = mk(4'hF, 4'hC, 32'h1,        32'h2,        0, 1, 4'd2,  0, 0, 32'h3,        4'b0010); // ORRNV
    tbl[11] = mk(4'h2, 4'hF, 32'h0,        32'h0,        0, 1, 4'd11, 1, 1, 32'hFFFFFFFF, 4'b1000); // MVNCS
    tbl[12] = mk(4'h3, 4'h7, 32'd5,        32'd3,        0, 1, 4'd12, 1, 1, 32'hFFFFFFFD, 4'b1000); // RSCCC C=0
    tbl[13] = mk(4'hE, 4'hE, 32'hFF,       32'h0F,       1, 0, 4'd13, 1, 1, 32'hF0,       4'b1000); // BIC no S
    tbl[14] = mk(4'h4, 4'h6, 32'h80000000, 32'h0,        0, 1, 4'd14, 1, 1, 32'h7FFFFFFF, 4'b0011); // SBCMI C=0
    tbl[15] = mk(4'h6, 4'hB, 32'hFFFFFFFF, 32'h1,        0, 0, 4'd15, 1, 0, 32'h0,        4'b0110); // CMNVS

    // Reset state
    rst = 1;
    drive(1, 0, 4'hE, 4'h4, 32'h5, 32'h6, 0, 1, 4'd7);
    tick(); tick();
    chk("reset out_valid", out_valid, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_addr", wr_addr, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset flags", flags, 4'b0000);
    chk("reset cond_pass", cond_pass, 0);
    rst = 0;
    drive(0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 0);
    chk("reset in_ready", in_ready, 1);

    // Directed table, back to back
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, tbl[i].cc, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sc, tbl[i].s, tbl[i].d);
      tick();
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d cond_pass", i), cond_pass, tbl[i].e_pass);
      chk($sformatf("vec%0d wr_en", i), wr_en, tbl[i].e_we);
      chk($sformatf("vec%0d wr_addr", i), wr_addr, tbl[i].d);
      chk($sformatf("vec%0d wr_data", i), wr_data, tbl[i].e_data);
      chk($sformatf("vec%0d flags", i), flags, tbl[i].e_flags);
    end
    drive(0, 0, 4'hE, 4'h0, 0, 0, 0, 0, 0);
    tick();
    chk("idle out_valid", out_valid, 0);
    chk("idle wr_en", wr_en, 0);
    chk("idle wr_data hold", wr_data, 32'h0);
    chk("idle flags hold", flags, 4'b0110);

    // Stall sequence: one pending result frozen for 3 cycles, then exactly one new write
    rst = 1; tick(); rst = 0;
    drive(1, 0, 4'hE, 4'h4, 32'd1, 32'd2, 0, 0, 4'd5);
    tick();
    chk("pre-stall wr_data", wr_data, 32'd3);
    drive(1, 1, 4'hE, 4'h4, 32'hFFFFFFFF, 32'h1, 0, 1, 4'd9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d in_ready", k), in_ready, 0);
      chk($sformatf("stall%0d out_valid", k), out_valid, 1);
      chk($sformatf("stall%0d wr_en", k), wr_en, 1);
      chk($sformatf("stall%0d wr_addr", k), wr_addr, 4'd5);
      chk($sformatf("stall%0d wr_data", k), wr_data, 32'd3);
      chk($sformatf("stall%0d flags", k), flags, 4'b0000);
    end
    stall = 0;
    wr_count = 0;
    tick();
    if (wr_en) wr_count++;
    chk("release wr_addr", wr_addr, 4'd9);
    chk("release wr_data", wr_data, 32'h0);
    chk("release flags", flags, 4'b0110);
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (wr_en) wr_count++;
    end
    chk("release write count", wr_count, 1);
    chk("release out_valid drop", out_valid, 0);

    // Reset during stall drops the held result
    drive(1, 0, 4'hE, 4'h4, 32'h7FFFFFFF, 32'h1, 0, 1, 4'd3);
    tick();
    chk("pre-rst flags", flags, 4'b1001);
    stall = 1; rst = 1;
    tick();
    chk("rst-stall out_valid", out_valid, 0);
    chk("rst-stall wr_en", wr_en, 0);
    chk("rst-stall flags", flags, 4'b0000);
    chk("rst-stall wr_data", wr_data, 32'h0);
    rst = 0; stall = 0;

    // Randomized run against the reference model
    rst = 1;
    model_step();
    tick();
    rst = 0;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
      model_step();
      tick();
      chk($sformatf("rnd%0d in_ready", i), in_ready, !stall);
      chk($sformatf("rnd%0d out_valid", i), out_valid, m_ov);
      chk($sformatf("rnd%0d wr_en", i), wr_en, m_we);
      chk($sformatf("rnd%0d wr_addr", i), wr_addr, m_wa);
      chk($sformatf("rnd%0d wr_data", i), wr_data, m_wd);
      chk($sformatf("rnd%0d flags", i), flags, m_fl);
      if (m_ov) chk($sformatf("rnd%0d cond_pass", i), cond_pass, m_cp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
